// File: rtl/mc_controller_if.sv
// rtl/mc_controller_if.sv - instruction fields in, datapath control strobes out
interface mc_controller_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pcen;
    logic       irwrite;
    logic       iord;
    logic       memwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic       ne;
    logic       half;
    logic       b;
    logic       illegal;
    logic [3:0] state;

    modport master (
        input  op, funct, zero,
        output pcen, irwrite, iord, memwrite, memtoreg, regdst, regwrite,
               alusrca, alusrcb, pcsrc, alucontrol, ne, half, b, illegal, state
    );

    modport slave (
        output op, funct, zero,
        input  pcen, irwrite, iord, memwrite, memtoreg, regdst, regwrite,
               alusrca, alusrcb, pcsrc, alucontrol, ne, half, b, illegal, state
    );
endinterface

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multicycle MIPS control FSM
// Moore strobes decoded from the state register; pcen and alucontrol are combinational.
module mc_controller #(
    parameter bit HALFBYTE_EN = 1'b1
) (
    input  logic           clk_i,
    input  logic           reset_i,
    mc_controller_if.master bus
);
    typedef enum logic [3:0] {
        S_INIT    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADR  = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_RTYPEEX = 4'd7,
        S_RTYPEWB = 4'd8,
        S_BRANCH  = 4'd9,
        S_ADDIEX  = 4'd10,
        S_ADDIWB  = 4'd11,
        S_JUMP    = 4'd12
    } state_e;

    typedef enum logic [1:0] {
        ALU_NONE  = 2'd0,
        ALU_ADD   = 2'd1,
        ALU_SUB   = 2'd2,
        ALU_FUNCT = 2'd3
    } aluop_e;

    state_e state_q, state_d;
    aluop_e aluop;
    logic   pcwrite;
    logic   branch;
    logic   is_lw, is_lh, is_lb, is_sw;

    assign is_lw = (bus.op == 6'b100011);
    assign is_sw = (bus.op == 6'b101011);
    // Halfword/byte loads vanish from the ISA entirely when the feature is off.
    assign is_lh = HALFBYTE_EN && (bus.op == 6'b100001);
    assign is_lb = HALFBYTE_EN && (bus.op == 6'b100000);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state_q <= S_INIT;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        aluop        = ALU_NONE;
        pcwrite      = 1'b0;
        branch       = 1'b0;
        bus.irwrite  = 1'b0;
        bus.iord     = 1'b0;
        bus.memwrite = 1'b0;
        bus.memtoreg = 1'b0;
        bus.regdst   = 1'b0;
        bus.regwrite = 1'b0;
        bus.alusrca  = 1'b0;
        bus.alusrcb  = 2'b00;
        bus.pcsrc    = 2'b00;
        bus.ne       = 1'b0;
        bus.half     = 1'b0;
        bus.b        = 1'b0;
        bus.illegal  = 1'b0;
        case (state_q)
            S_INIT: state_d = S_FETCH;
            S_FETCH: begin
                bus.irwrite = 1'b1;
                bus.alusrcb = 2'b01;
                aluop       = ALU_ADD;
                pcwrite     = 1'b1;
                state_d     = S_DECODE;
            end
            S_DECODE: begin
                bus.alusrcb = 2'b11;
                aluop       = ALU_ADD;
                if (is_lw || is_lh || is_lb || is_sw)             state_d = S_MEMADR;
                else if (bus.op == 6'b000000)                     state_d = S_RTYPEEX;
                else if (bus.op == 6'b000100 || bus.op == 6'b000101) state_d = S_BRANCH;
                else if (bus.op == 6'b001000)                     state_d = S_ADDIEX;
                else if (bus.op == 6'b000010)                     state_d = S_JUMP;
                else begin
                    bus.illegal = 1'b1;
                    state_d     = S_FETCH;
                end
            end
            S_MEMADR: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
                aluop       = ALU_ADD;
                state_d     = is_sw ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                bus.iord = 1'b1;
                bus.half = is_lh;
                bus.b    = is_lb;
                state_d  = S_MEMWB;
            end
            S_MEMWB: begin
                bus.memtoreg = 1'b1;
                bus.regwrite = 1'b1;
                bus.half     = is_lh;
                bus.b        = is_lb;
                state_d      = S_FETCH;
            end
            S_MEMWR: begin
                bus.iord     = 1'b1;
                bus.memwrite = 1'b1;
                state_d      = S_FETCH;
            end
            S_RTYPEEX: begin
                bus.alusrca = 1'b1;
                aluop       = ALU_FUNCT;
                state_d     = S_RTYPEWB;
            end
            S_RTYPEWB: begin
                bus.regdst   = 1'b1;
                bus.regwrite = 1'b1;
                state_d      = S_FETCH;
            end
            S_BRANCH: begin
                bus.alusrca = 1'b1;
                aluop       = ALU_SUB;
                bus.pcsrc   = 2'b01;
                branch      = 1'b1;
                bus.ne      = bus.op[0];
                state_d     = S_FETCH;
            end
            S_ADDIEX: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
                aluop       = ALU_ADD;
                state_d     = S_ADDIWB;
            end
            S_ADDIWB: begin
                bus.regwrite = 1'b1;
                state_d      = S_FETCH;
            end
            S_JUMP: begin
                bus.pcsrc = 2'b10;
                pcwrite   = 1'b1;
                state_d   = S_FETCH;
            end
            default: state_d = S_INIT;
        endcase
    end

    always_comb begin
        case (aluop)
            ALU_ADD: bus.alucontrol = 3'b010;
            ALU_SUB: bus.alucontrol = 3'b110;
            ALU_FUNCT: begin
                case (bus.funct)
                    6'b100000: bus.alucontrol = 3'b010;
                    6'b100010: bus.alucontrol = 3'b110;
                    6'b100100: bus.alucontrol = 3'b000;
                    6'b100101: bus.alucontrol = 3'b001;
                    6'b101010: bus.alucontrol = 3'b111;
                    default:   bus.alucontrol = 3'b010;
                endcase
            end
            default: bus.alucontrol = 3'b000;
        endcase
    end

    assign bus.pcen  = pcwrite | (branch & (bus.zero ^ bus.ne));
    assign bus.state = state_q;
endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multicycle control FSM for the MIPS core.
- Sequences the shared-memory, single-ALU datapath through fetch, decode, execute, memory and writeback. It does this by issuing per-cycle control strobes from the latched instruction opcode and funct.
- Counterpart to the single-cycle combinational decoder. Supports the same instruction set: R-type, lw, sw, lh, lb, addi, beq, bne, j.
- Sits between the instruction register and the multicycle datapath. Computes PC enable internally from the ALU zero flag.

Parameters:
- HALFBYTE_EN, 1, when 0 the lh/lb opcodes decode as illegal.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- op  in  6  instr[31:26] from the instruction register.
- funct  in  6  instr[5:0].
- zero  in  1  ALU zero flag, valid in the branch state.
- pcen  out  1  PC register enable.
- irwrite  out  1  instruction register load.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- memwrite  out  1  data memory write.
- memtoreg  out  1  register writeback select: 1 = memory data.
- regdst  out  1  destination select: 1 = rd, 0 = rt.
- regwrite  out  1  register file write.
- alusrca  out  1  ALU A select: 0 = PC, 1 = register A.
- alusrcb  out  2  ALU B select: 00 = B, 01 = 4, 10 = signimm, 11 = signimm<<2.
- pcsrc  out  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target.
- alucontrol  out  3  ALU operation.
- ne  out  1  branch sense: 1 = bne.
- half  out  1  halfword load in progress.
- b  out  1  byte load in progress.
- illegal  out  1  one-cycle pulse on an undecodable opcode.
- state  out  4  current state, for debug.

Behaviour:
- All outputs are registered-state Moore decodes, except pcen and alucontrol (see below).
- Async reset puts the FSM in INIT. In INIT every output is 0 and state = 0. INIT always goes to FETCH on the next edge.
- FETCH: iord=0, irwrite=1, alusrca=0, alusrcb=01, aluop=add, pcsrc=00, pcwrite=1. Next state: DECODE.
- DECODE: alusrca=0, alusrcb=11, aluop=add (branch target into ALUOut). Next state by op:
  - 100011 (lw), 101011 (sw), 100001 (lh), 100000 (lb) -> MEMADR.
  - 000000 -> RTYPEEX.
  - 000100 (beq), 000101 (bne) -> BRANCH.
  - 001000 -> ADDIEX.
  - 000010 -> JUMP.
  - Other op -> FETCH, with illegal=1 for that DECODE cycle. lh/lb are also illegal when HALFBYTE_EN=0.
- MEMADR: alusrca=1, alusrcb=10, aluop=add. Next: MEMRD for loads, MEMWR for sw.
- MEMRD: iord=1; half=1 for lh, b=1 for lb. Next: MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1; half/b held as in MEMRD. Next: FETCH.
- MEMWR: iord=1, memwrite=1. Next: FETCH.
- RTYPEEX: alusrca=1, alusrcb=00, aluop=funct. Next: RTYPEWB.
- RTYPEWB: regdst=1, memtoreg=0, regwrite=1. Next: FETCH.
- BRANCH: alusrca=1, alusrcb=00, aluop=sub, pcsrc=01, branch=1, ne=op[0]. Next: FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=add. Next: ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1. Next: FETCH.
- JUMP: pcsrc=10, pcwrite=1. Next: FETCH.
- pcen = pcwrite | (branch & (zero ^ ne)). This is combinational from zero.
- alucontrol, combinational from the state's aluop and funct:
  - aluop add -> 010; aluop sub -> 110.
  - aluop funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111, any other funct -> 010.
- Signals not listed for a state are 0 in that state.
- Latency, counted from FETCH to the next FETCH: lw/lh/lb 5 cycles; sw, R-type, addi 4; beq/bne, j 3; illegal 2.
- op and funct are sampled only in DECODE and later states. The datapath holds them stable because irwrite=1 only in FETCH.
- Reset asserted mid-instruction: immediate return to INIT, outputs 0 (no partial memwrite or regwrite). Restart at FETCH one cycle after reset deasserts.

Test Plan:
- Reset held 3 cycles, then released -> all outputs 0 during reset; state INIT then FETCH; irwrite=1 and pcen=1 in the first FETCH.
- op=100011 -> state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH; regwrite=1 and memtoreg=1 only in MEMWB; half=b=0.
- op=000101 with zero=0 -> pcen=1 in BRANCH with pcsrc=01 and alucontrol=110. Repeat with zero=1 -> pcen=0.
- op=000000 with funct 100100, 100101, 101010, 111111 -> alucontrol in RTYPEEX is 000, 001, 111, 010; regdst=1 in RTYPEWB.
- op=111111 -> illegal=1 for exactly one cycle in DECODE, then FETCH; no regwrite or memwrite pulse. Repeat op=100001 with HALFBYTE_EN=0 -> illegal.
- sw with reset asserted during MEMADR -> memwrite never 1; after release, FETCH follows INIT.
